// File: rtl/rsa_mod_in_collector_pkg.sv
// Shared RSA operand types plus the collector's word count and state encoding.
// The RSAModIn layout fixes the word order: modulus occupies the low bits and msg the high bits.
package rsa_mod_in_collector_pkg;

  localparam int MOD_WIDTH = 256;
  localparam int INT_WIDTH = 32;

  typedef logic [MOD_WIDTH-1:0] KeyType;
  typedef logic [INT_WIDTH-1:0] IntType;

  typedef struct packed {
    KeyType msg;
    KeyType key;
    KeyType modulus;
  } RSAModIn;

  localparam int MOD_IN_NWORD = $bits(RSAModIn) / INT_WIDTH;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } col_state_e;

  // Selects word idx of a flat operand set; word 0 is modulus[31:0].
  function automatic IntType mod_in_word(input RSAModIn set, input int idx);
    logic [$bits(RSAModIn)-1:0] flat;
    flat = set;
    return flat[idx*INT_WIDTH +: INT_WIDTH];
  endfunction

endpackage

// File: rtl/rsa_mod_in_collector_if.sv
// Word-stream input and wide-operand output handshakes of the collector.
// The master side is the host/bench; the slave side is the collector.
interface rsa_mod_in_collector_if
  import rsa_mod_in_collector_pkg::*;
#(
  parameter int WORD_W = INT_WIDTH,
  parameter int NWORD  = MOD_IN_NWORD
) ();

  logic                      i_valid;
  logic                      i_ready;
  logic [WORD_W-1:0]         i_word;
  logic                      i_flush;
  logic                      o_valid;
  logic                      o_ready;
  logic [WORD_W*NWORD-1:0]   o_data;

  modport master (
    output i_valid,
    output i_word,
    output i_flush,
    output o_ready,
    input  i_ready,
    input  o_valid,
    input  o_data
  );

  modport slave (
    input  i_valid,
    input  i_word,
    input  i_flush,
    input  o_ready,
    output i_ready,
    output o_valid,
    output o_data
  );

endinterface

// File: rtl/rsa_mod_in_collector.sv
// Assembles one RSAModIn operand set from a word stream in a right-shift register
// and holds it on a valid/ready output until the RSA core takes it.
module rsa_mod_in_collector
  import rsa_mod_in_collector_pkg::*;
#(
  parameter int WORD_W = INT_WIDTH,
  parameter int NWORD  = MOD_IN_NWORD
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rsa_mod_in_collector_if.slave  bus
);

  localparam int CNT_W  = $clog2(NWORD);
  localparam int DATA_W = WORD_W * NWORD;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NWORD - 1);

  col_state_e          state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [DATA_W-1:0]   shift_in;
  logic                accept;
  logic                release_set;

  // Ready/valid come straight from the state flop, so o_ready never reaches i_ready.
  assign bus.i_ready = (state_q == COLLECT);
  assign bus.o_valid = (state_q == HOLD);
  assign bus.o_data  = shift_q;

  assign accept      = bus.i_valid & (state_q == COLLECT) & ~bus.i_flush;
  assign release_set = (state_q == HOLD) & bus.o_ready;

  genvar gi;
  generate
    for (gi = 0; gi < NWORD; gi++) begin : g_lane
      if (gi == NWORD - 1) begin : g_top
        assign shift_in[gi*WORD_W +: WORD_W] = bus.i_word;
      end else begin : g_mid
        assign shift_in[gi*WORD_W +: WORD_W] = shift_q[(gi+1)*WORD_W +: WORD_W];
      end
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    shift_d = shift_q;

    if (bus.i_flush) begin
      // Shift contents are left as-is; the restarted count overwrites them anyway.
      state_d = COLLECT;
      count_d = '0;
    end else begin
      unique case (state_q)
        COLLECT: begin
          if (accept) begin
            shift_d = shift_in;
            if (count_q == LAST_CNT) begin
              count_d = '0;
              state_d = HOLD;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end
        HOLD: begin
          if (release_set) begin
            state_d = COLLECT;
          end
        end
        default: begin
          state_d = COLLECT;
          count_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      count_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_rsa_mod_in_collector.sv
// Directed bench for the operand collector: load, backpressure, gaps, flush,
// asynchronous reset in HOLD and back-to-back sets.
module tb_rsa_mod_in_collector;
  import rsa_mod_in_collector_pkg::*;

  typedef logic [$bits(RSAModIn)-1:0] vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;

  always #5 clk = ~clk;

  rsa_mod_in_collector_if bus ();

  rsa_mod_in_collector dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input vec_t got, input vec_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Offers one word and returns one step after the edge that accepted it.
  task automatic push(input IntType w);
    logic rdy;
    int   guard;
    guard = 0;
    bus.i_valid = 1'b1;
    bus.i_word  = w;
    do begin
      rdy = bus.i_ready;
      step();
      guard++;
    end while (!rdy && guard < 200);
    if (!rdy) check_eq("push_timeout", vec_t'(0), vec_t'(1));
  endtask

  task automatic push_set(input vec_t data);
    for (int k = 0; k < MOD_IN_NWORD; k++) push(data[k*INT_WIDTH +: INT_WIDTH]);
    bus.i_valid = 1'b0;
  endtask

  function automatic vec_t mk_seq(input IntType base);
    vec_t v;
    for (int k = 0; k < MOD_IN_NWORD; k++) v[k*INT_WIDTH +: INT_WIDTH] = base + IntType'(k);
    return v;
  endfunction

  vec_t   exp_v;
  vec_t   got_v;
  RSAModIn r;
  int     c1;
  int     c2;
  int     hits;
  IntType w;

  initial begin
    bus.i_valid = 1'b0;
    bus.i_word  = '0;
    bus.i_flush = 1'b0;
    bus.o_ready = 1'b1;

    #1;
    check_eq("rst_o_valid", vec_t'(bus.o_valid), vec_t'(0));
    check_eq("rst_i_ready", vec_t'(bus.i_ready), vec_t'(1));
    check_eq("rst_o_data",  bus.o_data,          vec_t'(0));
    #11;
    rst_n = 1'b1;
    step();

    // Basic load: words 1..24 back-to-back.
    push_set(mk_seq(32'h1));
    r = bus.o_data;
    check_eq("basic_o_valid",  vec_t'(bus.o_valid),           vec_t'(1));
    check_eq("basic_i_ready",  vec_t'(bus.i_ready),           vec_t'(0));
    check_eq("basic_mod_lo",   vec_t'(r.modulus[31:0]),       vec_t'(32'h1));
    check_eq("basic_mod_hi",   vec_t'(r.modulus[255:224]),    vec_t'(32'h8));
    check_eq("basic_key_lo",   vec_t'(r.key[31:0]),           vec_t'(32'h9));
    check_eq("basic_msg_hi",   vec_t'(r.msg[255:224]),        vec_t'(32'h18));
    check_eq("basic_data",     bus.o_data,                    mk_seq(32'h1));
    step();
    check_eq("basic_pulse_end", vec_t'(bus.o_valid),          vec_t'(0));
    check_eq("basic_ready_back", vec_t'(bus.i_ready),         vec_t'(1));

    // Backpressure: held 50 cycles while DEADBEEF waits on the input.
    bus.o_ready = 1'b0;
    exp_v = mk_seq(32'h100);
    push_set(exp_v);
    bus.i_valid = 1'b1;
    bus.i_word  = 32'hDEADBEEF;
    for (int k = 0; k < 50; k++) begin
      check_eq("bp_o_valid", vec_t'(bus.o_valid), vec_t'(1));
      check_eq("bp_i_ready", vec_t'(bus.i_ready), vec_t'(0));
      check_eq("bp_o_data",  bus.o_data,          exp_v);
      step();
    end
    bus.o_ready = 1'b1;
    exp_v = mk_seq(32'h200);
    exp_v[31:0] = 32'hDEADBEEF;
    push_set(exp_v);
    check_eq("bp_next_valid", vec_t'(bus.o_valid), vec_t'(1));
    check_eq("bp_next_data",  bus.o_data,          exp_v);
    step();

    // Gapped input: one valid cycle in every three.
    for (int k = 0; k < MOD_IN_NWORD; k++) begin
      w = $urandom;
      exp_v[k*INT_WIDTH +: INT_WIDTH] = w;
      if (k == MOD_IN_NWORD - 1)
        check_eq("gap_early_valid", vec_t'(bus.o_valid), vec_t'(0));
      bus.i_valid = 1'b1;
      bus.i_word  = w;
      step();
      bus.i_valid = 1'b0;
      bus.i_word  = $urandom;
      if (k != MOD_IN_NWORD - 1) begin
        step();
        step();
      end
    end
    check_eq("gap_o_valid", vec_t'(bus.o_valid), vec_t'(1));
    check_eq("gap_data",    bus.o_data,          exp_v);
    step();

    // Flush alongside word 11.
    for (int k = 0; k < 10; k++) push(32'h50 + IntType'(k));
    bus.i_flush = 1'b1;
    bus.i_valid = 1'b1;
    bus.i_word  = 32'hFFFFFFFF;
    step();
    bus.i_flush = 1'b0;
    bus.i_valid = 1'b0;
    check_eq("flush_o_valid", vec_t'(bus.o_valid), vec_t'(0));
    check_eq("flush_i_ready", vec_t'(bus.i_ready), vec_t'(1));
    push_set(mk_seq(32'hA0));
    r = bus.o_data;
    got_v = bus.o_data;
    hits = 0;
    for (int k = 0; k < MOD_IN_NWORD; k++)
      if (got_v[k*INT_WIDTH +: INT_WIDTH] == 32'hFFFFFFFF) hits++;
    check_eq("flush_o_valid2", vec_t'(bus.o_valid),     vec_t'(1));
    check_eq("flush_mod_lo",   vec_t'(r.modulus[31:0]), vec_t'(32'hA0));
    check_eq("flush_no_ffff",  vec_t'(hits),            vec_t'(0));
    check_eq("flush_data",     bus.o_data,              mk_seq(32'hA0));
    step();

    // Asynchronous reset while holding a set.
    bus.o_ready = 1'b0;
    push_set(mk_seq(32'h300));
    check_eq("ar_hold_valid", vec_t'(bus.o_valid), vec_t'(1));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_o_valid", vec_t'(bus.o_valid), vec_t'(0));
    check_eq("ar_i_ready", vec_t'(bus.i_ready), vec_t'(1));
    check_eq("ar_o_data",  bus.o_data,          vec_t'(0));
    @(negedge clk);
    rst_n = 1'b1;
    step();
    bus.o_ready = 1'b1;
    exp_v = mk_seq(32'h400);
    for (int k = 0; k < MOD_IN_NWORD - 1; k++) push(exp_v[k*INT_WIDTH +: INT_WIDTH]);
    check_eq("ar_count_restart", vec_t'(bus.o_valid), vec_t'(0));
    push(exp_v[(MOD_IN_NWORD-1)*INT_WIDTH +: INT_WIDTH]);
    bus.i_valid = 1'b0;
    check_eq("ar_reload_valid", vec_t'(bus.o_valid), vec_t'(1));
    check_eq("ar_reload_data",  bus.o_data,          exp_v);
    step();

    // Back-to-back sets: pulses 25 cycles apart.
    push_set(mk_seq(32'h500));
    c1 = cyc;
    check_eq("b2b_valid1", vec_t'(bus.o_valid), vec_t'(1));
    check_eq("b2b_data1",  bus.o_data,          mk_seq(32'h500));
    push_set(mk_seq(32'h600));
    c2 = cyc;
    check_eq("b2b_valid2", vec_t'(bus.o_valid), vec_t'(1));
    check_eq("b2b_data2",  bus.o_data,          mk_seq(32'h600));
    check_eq("b2b_period", vec_t'(c2 - c1),     vec_t'(25));
    step();
    check_eq("b2b_end", vec_t'(bus.o_valid), vec_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
